alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Shares one ALU function unit between NREQ requesters. A round-robin arbiter grants
//  one operation at a time; a small FSM sequences execution and returns the result
//  tagged with the requester id. Sits between client blocks and the ALU datapath.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  DATA_W   8   operand width
//  RES_W    16  result width (>= 2*DATA_W)
//  MUL_CYC  2   execute cycles for multiply (>= 1); add/sub take 1
// PORTS
//  clk         in   1              clock; all logic on posedge
//  rst         in   1              synchronous, active-low reset
//  req_valid   in   NREQ           per-requester operation valid
//  req_ready   out  NREQ           one-hot grant; handshake when valid&ready
//  req_a       in   NREQ*DATA_W    packed operand A; requester i at [i*DATA_W +: DATA_W]
//  req_b       in   NREQ*DATA_W    packed operand B; same packing
//  req_op      in   NREQ*4         packed 4-bit opcode; only [1:0] is decoded
//  rsp_valid   out  1              result valid
//  rsp_ready   in   1              consumer accepts result
//  rsp_id      out  $clog2(NREQ)   index of the granted requester
//  rsp_result  out  RES_W          result
//  rsp_err     out  1              illegal opcode flag (present only with ALU_SCHED_ERR_EN)
//  busy        out  1              high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0,
//   rsp_result=0, rsp_err=0. req_ready and busy read 0 while rst==0.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: req_ready is combinational. Grant the first requester with req_valid=1,
//    searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
//    At most one req_ready bit is set, and never while not in IDLE. On the grant edge:
//    latch A, B, op and id; set rr_ptr = (id+1) mod NREQ; go to EXEC with cnt=0.
//    With no valid request: stay in IDLE, rr_ptr unchanged.
//   EXEC: op 00 = add; op 01 = sub; op 10 = mul; op 11 = illegal, result 0.
//    Add/sub/illegal take 1 cycle. Mul takes MUL_CYC cycles (cnt counts up to MUL_CYC-1).
//    On the last cycle, register rsp_result and rsp_id and go to RESP.
//   RESP: rsp_valid=1. rsp_result, rsp_id and rsp_err hold stable until rsp_valid&rsp_ready.
//    On that edge: rsp_valid=0 and go to IDLE. No new grant in the same cycle.
//  Latency (grant edge at cycle T): rsp_valid rises at T+2 for add/sub/illegal and at
//   T+1+MUL_CYC for mul. Minimum issue interval is 3 cycles.
//  Arithmetic: operands zero-extended to RES_W. add = A+B. sub = A-B modulo 2^RES_W
//   (two's-complement wrap). mul = full unsigned A*B.
//  Fairness: with all requesters valid, a requester waits at most NREQ-1 grants.
//  Requester inputs may change freely while not granted; they are sampled only on the grant edge.
//  Reset asserted mid-EXEC or mid-RESP aborts the operation. No response is issued;
//   the block returns to IDLE with rr_ptr=0.
// CONFIGURATION
//  ALU_SCHED_ERR_EN defined: rsp_err port exists; it is set in RESP when op==11,
//   otherwise 0; it holds and clears with rsp_valid.
//  ALU_SCHED_ERR_EN undefined: no rsp_err port. op 11 returns 0 silently.
// STRUCTURE
//  alu_sched_pkg: OP_ADD/OP_SUB/OP_MUL/OP_ILL localparams (2-bit) and the state_t enum
//   {IDLE, EXEC, RESP}.
//  Sub-module alu_sched_fu: latched operands/op in, cycle counter, done pulse, registered
//   result. The top level holds the arbiter, rr_ptr, FSM and response registers.
// TESTING
//  1 Reset: drive rst=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0;
//    the first grant after release goes to requester 0.
//  2 req0: A=3, B=5, op=01 -> grant at T; rsp_valid at T+2, rsp_result=16'hFFFE, rsp_id=0.
//  3 req2: A=255, B=255, op=10, MUL_CYC=2 -> rsp at T+3, rsp_result=16'hFE01, rsp_id=2.
//  4 All 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1, one grant every 3 cycles.
//  5 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout;
//    the next grant occurs the cycle after the accept.
//  6 Reset during EXEC of a mul -> next cycle rsp_valid=0, busy=0, rr_ptr=0.
//    With ALU_SCHED_ERR_EN: op=11 -> rsp_err=1, rsp_result=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the ALU scheduler.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_sched_fu.sv
// ALU function unit: latches operands/op on start, counts execute cycles,
// raises done_c on the last execute cycle and presents the result.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start           load a_in/b_in/op_in (grant edge)
//   exec            scheduler is in its execute state
//   a_in, b_in      operands from the granted requester
//   op_in           2-bit opcode
//   done_c          last execute cycle (combinational)
//   result_c        result of the latched operation (combinational from latched operands)
//   ill_c           latched op is illegal (only with ALU_SCHED_ERR_EN)
// Optional feature macro: ALU_SCHED_ERR_EN
module alu_sched_fu
  import alu_sched_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned MUL_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              exec,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [1:0]        op_in,
  output logic              done_c,
`ifdef ALU_SCHED_ERR_EN
  output logic              ill_c,
`endif
  output logic [RES_W-1:0]  result_c
);

  localparam int unsigned CNT_W = clog2_min1(MUL_CYC);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Multiply is the only multi-cycle op; everything else finishes in one cycle.
  always_comb begin
    done_c = exec && ((op_q != OP_MUL) || (cnt_q == CNT_W'(MUL_CYC - 1)));
  end

`ifdef ALU_SCHED_ERR_EN
  always_comb begin
    ill_c = (op_q == OP_ILL);
  end
`endif

  // Operand capture and execute-cycle counter.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = a_in;
      b_d   = b_in;
      op_d  = op_in;
      cnt_d = '0;
    end else if (exec && !done_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath on zero-extended operands; sub wraps modulo 2^RES_W.
  always_comb begin
    result_c = '0;
    case (op_q)
      OP_ADD:  result_c = RES_W'(a_q) + RES_W'(b_q);
      OP_SUB:  result_c = RES_W'(a_q) - RES_W'(b_q);
      OP_MUL:  result_c = RES_W'(a_q) * RES_W'(b_q);
      default: result_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU function unit between NREQ requesters: round-robin arbiter,
// IDLE->EXEC->RESP sequencer and response registers tagged with requester id.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   req_valid     per-requester valid
//   req_ready     one-hot grant (combinational, only in IDLE)
//   req_a/req_b   packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_op        packed 4-bit opcodes, only [1:0] decoded
//   rsp_valid/rsp_ready  response handshake
//   rsp_id        granted requester index
//   rsp_result    result
//   rsp_err       illegal-opcode flag (only with ALU_SCHED_ERR_EN)
//   busy          not in IDLE
// Optional feature macro: ALU_SCHED_ERR_EN
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned MUL_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*4-1:0]        req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [RES_W-1:0]         rsp_result,
`ifdef ALU_SCHED_ERR_EN
  output logic                     rsp_err,
`endif
  output logic                     busy
);

  localparam int unsigned ID_W = clog2_min1(NREQ);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
  logic              busy_q, busy_d;
`ifdef ALU_SCHED_ERR_EN
  logic              err_q, err_d;
  logic              fu_ill_c;
`endif

  logic              gnt_any_c;
  logic [ID_W-1:0]   gnt_id_c;
  logic [NREQ-1:0]   gnt_oh_c;
  logic [DATA_W-1:0] a_sel_c, b_sel_c;
  logic [1:0]        op_sel_c;
  logic              start_c;
  logic              fu_done_c;
  logic [RES_W-1:0]  fu_result_c;
  logic              unused_op_hi;

  // Round-robin search starting at rr_q with wrap.
  always_comb begin
    int unsigned     pos;
    logic [ID_W-1:0] idx;
    gnt_any_c = 1'b0;
    gnt_id_c  = '0;
    gnt_oh_c  = '0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(rr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = ID_W'(pos);
      if (!gnt_any_c && req_valid[idx]) begin
        gnt_any_c = 1'b1;
        gnt_id_c  = idx;
      end
    end
    if (rst && (state_q == IDLE) && gnt_any_c) gnt_oh_c[gnt_id_c] = 1'b1;
  end

  // Operand mux for the granted requester; upper opcode bits are ignored.
  always_comb begin
    a_sel_c      = '0;
    b_sel_c      = '0;
    op_sel_c     = OP_ADD;
    unused_op_hi = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      unused_op_hi = unused_op_hi ^ (^req_op[i*4+2 +: 2]);
      if (gnt_id_c == ID_W'(i)) begin
        a_sel_c  = req_a[i*DATA_W +: DATA_W];
        b_sel_c  = req_b[i*DATA_W +: DATA_W];
        op_sel_c = req_op[i*4 +: 2];
      end
    end
  end

  alu_sched_fu #(
    .DATA_W  (DATA_W),
    .RES_W   (RES_W),
    .MUL_CYC (MUL_CYC)
  ) u_fu (
    .clk      (clk),
    .rst      (rst),
    .start    (start_c),
    .exec     (state_q == EXEC),
    .a_in     (a_sel_c),
    .b_in     (b_sel_c),
    .op_in    (op_sel_c),
    .done_c   (fu_done_c),
`ifdef ALU_SCHED_ERR_EN
    .ill_c    (fu_ill_c),
`endif
    .result_c (fu_result_c)
  );

  // Sequencer next-state and response registers.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    start_c      = 1'b0;
`ifdef ALU_SCHED_ERR_EN
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          start_c = 1'b1;
          id_d    = gnt_id_c;
          rr_d    = (gnt_id_c == ID_W'(NREQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (fu_done_c) begin
          rsp_result_d = fu_result_c;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
`ifdef ALU_SCHED_ERR_EN
          err_d        = fu_ill_c;
`endif
          state_d      = RESP;
        end
      end
      RESP: begin
        // Accept returns to IDLE; arbitration resumes the following cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef ALU_SCHED_ERR_EN
          err_d       = 1'b0;
`endif
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
`ifdef ALU_SCHED_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      busy_q       <= busy_d;
`ifdef ALU_SCHED_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  // req_ready and busy are forced low while reset is held.
  assign req_ready  = gnt_oh_c;
  assign busy       = busy_q & rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
`ifdef ALU_SCHED_ERR_EN
  assign rsp_err    = err_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_alu_sched;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 8;
  localparam int RES_W   = 16;
  localparam int MUL_CYC = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*DATA_W-1:0]  req_a;
  logic [NREQ*DATA_W-1:0]  req_b;
  logic [NREQ*4-1:0]       req_op;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [RES_W-1:0]        rsp_result;
  logic                    busy;
`ifdef ALU_SCHED_ERR_EN
  logic                    rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  alu_sched #(
    .NREQ(NREQ), .DATA_W(DATA_W), .RES_W(RES_W), .MUL_CYC(MUL_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
`ifdef ALU_SCHED_ERR_EN
    .rsp_err    (rsp_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
    logic [RES_W-1:0]  res;
    int                lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level arithmetic on zero-extended operands.
  function automatic logic [RES_W-1:0] ref_alu(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: r = 0;
    endcase
    return r[RES_W-1:0];
  endfunction

  // First valid requester at or after ptr, with wrap; -1 if none.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int oh_to_id(input logic [NREQ-1:0] oh);
    for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    logic [NREQ-1:0] oh;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_a[v.id*DATA_W +: DATA_W] = v.a;
    req_b[v.id*DATA_W +: DATA_W] = v.b;
    req_op[v.id*4 +: 4] = {2'b00, v.op};
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    oh = '0;
    oh[v.id] = 1'b1;
    chk("vec_grant", 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    req_valid = '0;
    req_a = $urandom;
    req_b = $urandom;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("vec_latency", 32'(n), 32'(v.lat));
    chk("vec_result", 32'(rsp_result), 32'(v.res));
    chk("vec_id", 32'(rsp_id), 32'(v.id));
`ifdef ALU_SCHED_ERR_EN
    chk("vec_err", 32'(rsp_err), 32'(v.op == 2'b11));
`endif
    @(posedge clk);
  endtask

  task automatic idle_drain(input int cyc);
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (cyc) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[6];
    int gcyc[6];
    int ng, cyc, n, g;
    logic [NREQ-1:0] oh;

    vecs[0] = '{0, 8'd3,   8'd5,   2'b01, 16'hFFFE, 2};
    vecs[1] = '{2, 8'd255, 8'd255, 2'b10, 16'hFE01, 3};
    vecs[2] = '{1, 8'd255, 8'd255, 2'b00, 16'h01FE, 2};
    vecs[3] = '{3, 8'd0,   8'd1,   2'b01, 16'hFFFF, 2};
    vecs[4] = '{1, 8'd16,  8'd16,  2'b10, 16'h0100, 3};
    vecs[5] = '{3, 8'd200, 8'd100, 2'b11, 16'h0000, 2};
    vecs[6] = '{0, 8'd0,   8'd0,   2'b00, 16'h0000, 2};
    vecs[7] = '{2, 8'd0,   8'd77,  2'b10, 16'h0000, 3};

    // Reset with every requester valid.
    rst = 1'b0;
    req_valid = '1;
    req_op = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) req_a[i*DATA_W +: DATA_W] = DATA_W'(i);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(rsp_result), 0);
    chk("rst_id", 32'(rsp_id), 0);

    // Release: round-robin order and issue interval with all valid.
    @(posedge clk); #1;
    rst = 1'b1;
    ng = 0;
    cyc = 0;
    while (ng < 6 && cyc < 40) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rr_onehot", 32'($countones(req_ready)), 1);
        grants[ng] = oh_to_id(req_ready);
        gcyc[ng] = cyc;
        ng++;
      end
      cyc++;
    end
    chk("rr_count", 32'(ng), 6);
    for (int k = 0; k < ng; k++) begin
      chk("rr_order", 32'(grants[k]), 32'(k % NREQ));
      if (k > 0) chk("rr_interval", 32'(gcyc[k] - gcyc[k-1]), 3);
    end
    idle_drain(6);

    // Directed vector table.
    foreach (vecs[i]) run_vec(vecs[i]);
    idle_drain(3);

    // Response back-pressure: outputs hold, no grants until accept.
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DATA_W +: DATA_W] = DATA_W'(10 + i);
      req_b[i*DATA_W +: DATA_W] = DATA_W'(i);
      req_op[i*4 +: 4] = 4'b0000;
    end
    req_valid = '1;
    rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    g = oh_to_id(req_ready);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_result", 32'(rsp_result), 32'(10 + 2 * g));
      chk("stall_id", 32'(rsp_id), 32'(g));
      chk("stall_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    oh = '0;
    oh[(g + 1) % NREQ] = 1'b1;
    chk("stall_release_valid", 32'(rsp_valid), 0);
    chk("stall_next_grant", 32'(req_ready), 32'(oh));
    idle_drain(6);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_a[2*DATA_W +: DATA_W] = 8'd200;
    req_b[2*DATA_W +: DATA_W] = 8'd3;
    req_op[2*4 +: 4] = 4'b0010;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    chk("abort_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rr_ptr", 32'(req_ready), 32'h1);
    idle_drain(6);

    // Randomized run against a transaction-level model.
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    begin
      int m_phase;   // 0 idle, 1 executing, 2 responding
      int m_ptr, m_wait, m_id, m_op;
      logic [RES_W-1:0] m_res;
      m_phase = 0;
      m_ptr = 0;
      m_wait = 0;
      m_id = 0;
      m_op = 0;
      m_res = '0;
      for (int c = 0; c < 2000; c++) begin
        if (c != 0) begin @(posedge clk); #1; end
        req_valid = NREQ'($urandom);
        req_a = $urandom;
        req_b = $urandom;
        req_op = $urandom;
        rsp_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        case (m_phase)
          0: begin
            int p;
            p = pick(req_valid, m_ptr);
            oh = '0;
            if (p >= 0) oh[p] = 1'b1;
            chk("rnd_ready", 32'(req_ready), 32'(oh));
            chk("rnd_idle_valid", 32'(rsp_valid), 0);
            chk("rnd_idle_busy", 32'(busy), 0);
            if (p >= 0) begin
              m_id = p;
              m_op = int'(req_op[p*4 +: 2]);
              m_res = ref_alu(int'(req_a[p*DATA_W +: DATA_W]),
                              int'(req_b[p*DATA_W +: DATA_W]), m_op);
              m_wait = (m_op == 2) ? MUL_CYC : 1;
              m_ptr = (p + 1) % NREQ;
              m_phase = 1;
            end
          end
          1: begin
            chk("rnd_exec_ready", 32'(req_ready), 0);
            chk("rnd_exec_valid", 32'(rsp_valid), 0);
            chk("rnd_exec_busy", 32'(busy), 1);
            m_wait--;
            if (m_wait == 0) m_phase = 2;
          end
          default: begin
            chk("rnd_resp_valid", 32'(rsp_valid), 1);
            chk("rnd_resp_id", 32'(rsp_id), 32'(m_id));
            chk("rnd_resp_result", 32'(rsp_result), 32'(m_res));
            chk("rnd_resp_ready", 32'(req_ready), 0);
            chk("rnd_resp_busy", 32'(busy), 1);
`ifdef ALU_SCHED_ERR_EN
            chk("rnd_resp_err", 32'(rsp_err), 32'(m_op == 3));
`endif
            if (rsp_ready) m_phase = 0;
          end
        endcase
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
